// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single uart_tx transmitter among NREQ byte sources. One byte is
// granted at a time in round-robin order. The byte is latched onto tx_data and
// launched with a one-cycle tx_trigger pulse. Because the transmitter reports
// no busy status, further launches are held off for a locally timed frame
// interval of FRAME_CYCLES clocks.
//
// Ports
//   clk        : single clock for the whole block
//   rst_n      : asynchronous active-low reset
//   req        : per-requester request; bit i qualifies req_data slice i
//   req_data   : flattened bytes, slice i = [i*datawidth +: datawidth]
//   ack        : one-hot, one-cycle pulse; requester i's byte was taken
//   tx_data    : byte presented to uart_tx.data_in, held until the next grant
//   tx_trigger : one-cycle launch pulse to uart_tx.tx_triger_flag
//   busy       : high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int datawidth = 8,
   parameter int Baudrate  = 9600,
   parameter int CLK_FREQ  = 50_000_000,
   parameter int NREQ      = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*datawidth-1:0] req_data,
   output logic [NREQ-1:0]           ack,
   output logic [datawidth-1:0]      tx_data,
   output logic                      tx_trigger,
   output logic                      busy
);

   localparam int BIT_CYCLES   = CLK_FREQ / Baudrate;
   localparam int FRAME_CYCLES = BIT_CYCLES * (datawidth + 2);
   localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int IDX_W        = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     last;

   logic [IDX_W-1:0]     winner;
   logic [IDX_W-1:0]     idx;
   logic                 found;
   logic [datawidth-1:0] win_data;

   // Round-robin pick: first set request scanning last+1, last+2, ... with
   // wrap-around, so the previous winner has the lowest priority.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so
      // no path leaves it unassigned, which would infer a latch.
      winner = last;
      found  = 1'b0;
      idx    = '0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = IDX_W'((int'(last) + off) % NREQ);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // Byte of the selected requester, muxed with constant slice offsets.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == IDX_W'(i)) begin
            win_data = req_data[i*datawidth +: datawidth];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         last       <= LAST_INIT;
         ack        <= '0;
         tx_data    <= '0;
         tx_trigger <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout so every register here
         // samples pre-edge values, independent of statement order.
         case (state)
            IDLE: begin
               if (found) begin
                  tx_data     <= win_data;
                  ack         <= '0;
                  ack[winner] <= 1'b1;
                  last        <= winner;
                  busy        <= 1'b1;
                  state       <= LAUNCH;
               end
            end
            LAUNCH: begin
               ack        <= '0;
               tx_trigger <= 1'b1;
               cnt        <= CNT_LOAD;
               state      <= WAIT;
            end
            WAIT: begin
               tx_trigger <= 1'b0;
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with CLK_FREQ=100, Baudrate=10,
// datawidth=8, NREQ=4 (FRAME_CYCLES=100). Stimulus pushes the expected
// {ack, tx_data} of every grant into a queue; an independent monitor pops and
// compares whenever ack pulses, and checks that tx_trigger follows ack by
// exactly one cycle. Timing properties are checked in the stimulus thread.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int DW    = 8;
   localparam int NREQ  = 4;
   localparam int FRAME = 100;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic [DW-1:0]     tx_data;
   logic              tx_trigger;
   logic              busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .datawidth (DW),
      .Baudrate  (10),
      .CLK_FREQ  (100),
      .NREQ      (NREQ)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_data   (req_data),
      .ack        (ack),
      .tx_data    (tx_data),
      .tx_trigger (tx_trigger),
      .busy       (busy)
   );

   typedef struct packed {
      logic [NREQ-1:0] ack;
      logic [DW-1:0]   data;
   } exp_t;

   exp_t exp_q[$];
   int   trig_cyc[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      n_checks++;
      $display("FAIL %s: observed 0x%0h (cycle %0d)", name, act, cyc);
   endtask

   // ---------------------------------------------------------------- monitor
   logic prev_ack = 1'b0;
   exp_t mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ack = 1'b0;
      end else begin
         if (ack != '0) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_ack", 32'(ack));
            end else begin
               mon_e = exp_q.pop_front();
               check("grant_ack", 32'(ack), 32'(mon_e.ack));
               check("grant_tx_data", 32'(tx_data), 32'(mon_e.data));
               check("busy_during_ack", 32'(busy), 32'd1);
            end
         end
         if (tx_trigger || prev_ack) check("trigger_one_after_ack", 32'(tx_trigger), 32'(prev_ack));
         if (tx_trigger) trig_cyc.push_back(cyc);
         prev_ack = (ack != '0);
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic set_byte(input int i, input logic [DW-1:0] val);
      req_data[i*DW +: DW] = val;
   endtask

   task automatic wait_any_ack(output int idx, input int budget);
      idx = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (ack != '0) begin
            for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
            return;
         end
      end
      fail_now("ack_timeout", 32'(req));
   endtask

   task automatic wait_idle(input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (!busy) return;
      end
      fail_now("idle_timeout", 32'(busy));
   endtask

   task automatic wait_trigger(input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (tx_trigger) return;
      end
      fail_now("trigger_timeout", 32'(tx_trigger));
   endtask

   task automatic do_reset();
      req   = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_clear(input string tag);
      check({tag, "_ack"},        32'(ack),        32'd0);
      check({tag, "_tx_data"},    32'(tx_data),    32'd0);
      check({tag, "_tx_trigger"}, 32'(tx_trigger), 32'd0);
      check({tag, "_busy"},       32'(busy),       32'd0);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int idx;
      int t0;
      int n;
      int ka;
      int kb;

      req      = '0;
      req_data = '0;
      rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_clear("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single request from requester 2.
      set_byte(2, 8'hA5);
      exp_q.push_back('{ack: 4'b0100, data: 8'hA5});
      t0  = trig_cyc.size();
      req = 4'b0100;
      wait_any_ack(idx, 20);
      req = '0;
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      // busy spans grant edge k up to the IDLE re-entry edge k+1+FRAME.
      check("t1_busy_cycles", 32'(n), 32'(FRAME + 1));
      check("t1_trigger_count", 32'(trig_cyc.size() - t0), 32'd1);
      check("t1_tx_data_held", 32'(tx_data), 32'hA5);

      // All four requesters, each dropping its request on ack.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         set_byte(i, 8'(8'h10 + i));
         exp_q.push_back('{ack: 4'(1 << i), data: 8'(8'h10 + i)});
      end
      t0  = trig_cyc.size();
      req = 4'b1111;
      for (int g = 0; g < NREQ; g++) begin
         wait_any_ack(idx, 300);
         if (idx >= 0) req[idx] = 1'b0;
      end
      wait_idle(300);
      check("t2_trigger_count", 32'(trig_cyc.size() - t0), 32'd4);
      if (trig_cyc.size() - t0 == 4) begin
         for (int g = 1; g < 4; g++)
            check("t2_trigger_spacing", 32'(trig_cyc[t0+g] - trig_cyc[t0+g-1]), 32'(FRAME + 2));
      end

      // Fairness: requesters 0 and 2 held for four frames.
      do_reset();
      set_byte(0, 8'h20);
      set_byte(1, 8'h21);
      set_byte(2, 8'h22);
      for (int g = 0; g < 2; g++) begin
         exp_q.push_back('{ack: 4'b0001, data: 8'h20});
         exp_q.push_back('{ack: 4'b0100, data: 8'h22});
      end
      req = 4'b0101;
      for (int g = 0; g < 4; g++) wait_any_ack(idx, 300);
      req = '0;
      wait_idle(300);

      // Reset in the middle of WAIT.
      do_reset();
      set_byte(0, 8'h30);
      exp_q.push_back('{ack: 4'b0001, data: 8'h30});
      req = 4'b0001;
      wait_any_ack(idx, 20);
      req = '0;
      wait_trigger(10);
      repeat (40) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_clear("t4_async");
      set_byte(3, 8'h33);
      exp_q.push_back('{ack: 4'b1000, data: 8'h33});
      req = 4'b1000;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t4_ack_first_edge", 32'(ack), 32'b1000);
      req = '0;
      wait_idle(300);

      // Request raised and withdrawn while busy: never granted.
      set_byte(0, 8'h40);
      exp_q.push_back('{ack: 4'b0001, data: 8'h40});
      req = 4'b0001;
      wait_any_ack(idx, 20);
      req = '0;
      t0  = trig_cyc.size();
      repeat (20) @(negedge clk);
      set_byte(1, 8'h55);
      req = 4'b0010;
      repeat (10) @(negedge clk);
      req = '0;
      wait_idle(300);
      repeat (5) @(negedge clk);
      check("t5_tx_data_unchanged", 32'(tx_data), 32'h40);
      check("t5_trigger_count", 32'(trig_cyc.size() - t0), 32'd1);

      // Late arrival during WAIT: granted on the first IDLE edge.
      set_byte(0, 8'h60);
      exp_q.push_back('{ack: 4'b0001, data: 8'h60});
      req = 4'b0001;
      wait_any_ack(idx, 20);
      ka  = cyc;
      req = '0;
      wait_trigger(10);
      repeat (10) @(negedge clk);
      set_byte(3, 8'h63);
      exp_q.push_back('{ack: 4'b1000, data: 8'h63});
      req = 4'b1000;
      wait_any_ack(idx, 300);
      kb  = cyc;
      check("t6_late_winner", 32'(idx), 32'd3);
      check("t6_grant_spacing", 32'(kb - ka), 32'(FRAME + 2));
      req = '0;
      wait_idle(300);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
